// File: rtl/branch_redirect_ctrl.sv
// Branch resolution and fetch redirect controller.
// Resolves EX branches, hands the target to fetch, then walks a flush/stall pattern.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   br_valid            EX holds a valid instruction
//   opcode, op, cond    decode fields of the EX instruction
//   pc, sximm           PC and sign-extended offset for PC-relative targets
//   rd_val              BX target source
//   rspecial_val        BLX target source
//   z, n, v             status flags
//   redirect_ready      fetch accepts the redirect
//   redirect_valid      redirect target presented to fetch
//   redirect_pc         registered redirect target
//   flush               per-stage flush, bit 0 is IF
//   stall_ex            hold the EX stage
//   branch_taken        combinational taken decision
//   busy                controller not idle
//   taken_count         saturating count of accepted redirects
module branch_redirect_ctrl #(
  parameter int PC_W         = 9,
  parameter int DATA_W       = 16,
  parameter int FLUSH_DEPTH  = 3,
  parameter int STALL_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        cond,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] sximm,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] rspecial_val,
  input  logic              z,
  input  logic              n,
  input  logic              v,
  input  logic              redirect_ready,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic              stall_ex,
  output logic              branch_taken,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int CW = $clog2(FLUSH_DEPTH + 1);

  localparam logic [7:0] K_B   = 8'b00100_000;
  localparam logic [7:0] K_BEQ = 8'b00100_001;
  localparam logic [7:0] K_BNE = 8'b00100_010;
  localparam logic [7:0] K_BLT = 8'b00100_011;
  localparam logic [7:0] K_BLE = 8'b00100_100;
  localparam logic [4:0] K_BX  = 5'b01000;
  localparam logic [4:0] K_BLX = 5'b01010;
  localparam logic [4:0] K_CALL = 5'b01011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [7:0]      k;
  logic [4:0]      k_hi;
  logic            taken;
  logic            sel_bx;
  logic            sel_blx;
  logic [PC_W-1:0] target;

  assign k    = {opcode, op, cond};
  assign k_hi = {opcode, op};

  always_comb begin
    taken   = 1'b0;
    sel_bx  = 1'b0;
    sel_blx = 1'b0;
    unique case (1'b1)
      (k == K_B):      taken = 1'b1;
      (k == K_BEQ):    taken = z;
      (k == K_BNE):    taken = ~z;
      (k == K_BLT):    taken = n ^ v;
      (k == K_BLE):    taken = (n ^ v) | z;
      (k_hi == K_BX): begin
        taken  = 1'b1;
        sel_bx = 1'b1;
      end
      (k_hi == K_BLX): begin
        taken   = 1'b1;
        sel_blx = 1'b1;
      end
      (k_hi == K_CALL): taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

  // PC-relative targets wrap silently at 2^PC_W.
  always_comb begin
    target = pc + sximm[PC_W-1:0] + PC_W'(1);
    if (sel_bx)
      target = rd_val[PC_W-1:0];
    else if (sel_blx)
      target = rspecial_val[PC_W-1:0];
  end

  generate
    if (DATA_W > PC_W) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{sximm[DATA_W-1:PC_W],
                           rd_val[DATA_W-1:PC_W],
                           rspecial_val[DATA_W-1:PC_W]};
    end
  endgenerate

  assign branch_taken = br_valid & taken & (state == S_IDLE);

  // Stages at or above c stay flushed; the youngest release first.
  function automatic logic [FLUSH_DEPTH-1:0] flush_mask(
    input logic [CW-1:0] c
  );
    logic [FLUSH_DEPTH-1:0] m;
    for (int i = 0; i < FLUSH_DEPTH; i++)
      m[i] = (i >= int'(c));
    return m;
  endfunction

  function automatic logic stall_of(input logic [CW-1:0] c);
    return int'(c) <= STALL_CYCLES;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      redirect_pc    <= '0;
      redirect_valid <= 1'b0;
      flush          <= '0;
      stall_ex       <= 1'b0;
      busy           <= 1'b0;
      taken_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (branch_taken) begin
            state          <= S_REDIR;
            redirect_pc    <= target;
            redirect_valid <= 1'b1;
            flush          <= '1;
            stall_ex       <= 1'b1;
            busy           <= 1'b1;
          end else begin
            redirect_valid <= 1'b0;
            flush          <= '0;
            stall_ex       <= 1'b0;
            busy           <= 1'b0;
          end
        end
        S_REDIR: begin
          if (redirect_ready) begin
            state          <= S_FLUSH;
            cnt            <= CW'(1);
            redirect_valid <= 1'b0;
            flush          <= flush_mask(CW'(1));
            stall_ex       <= stall_of(CW'(1));
            busy           <= 1'b1;
            if (taken_count != '1)
              taken_count <= taken_count + CNT_W'(1);
          end
        end
        S_FLUSH: begin
          if (cnt == CW'(FLUSH_DEPTH)) begin
            state          <= S_IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            flush          <= '0;
            stall_ex       <= 1'b0;
            busy           <= 1'b0;
          end else begin
            cnt      <= cnt + CW'(1);
            flush    <= flush_mask(cnt + CW'(1));
            stall_ex <= stall_of(cnt + CW'(1));
            busy     <= 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          cnt            <= '0;
          redirect_valid <= 1'b0;
          flush          <= '0;
          stall_ex       <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl.
// Checks decode, targets, handshake, flush sequencing, reset and a deep-flush build.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic        br_valid2;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  cond;
  logic [8:0]  pc;
  logic [15:0] sximm;
  logic [15:0] rd_val;
  logic [15:0] rspecial_val;
  logic        z, n, v;
  logic        redirect_ready;

  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic [2:0]  flush;
  logic        stall_ex;
  logic        branch_taken;
  logic        busy;
  logic [15:0] taken_count;

  logic        redirect_valid2;
  logic [8:0]  redirect_pc2;
  logic [4:0]  flush2;
  logic        stall_ex2;
  logic        branch_taken2;
  logic        busy2;
  logic [15:0] taken_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk(clk), .reset(reset), .br_valid(br_valid),
    .opcode(opcode), .op(op), .cond(cond), .pc(pc),
    .sximm(sximm), .rd_val(rd_val),
    .rspecial_val(rspecial_val),
    .z(z), .n(n), .v(v),
    .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush),
    .stall_ex(stall_ex), .branch_taken(branch_taken),
    .busy(busy), .taken_count(taken_count)
  );

  branch_redirect_ctrl #(
    .FLUSH_DEPTH(5), .STALL_CYCLES(0)
  ) dut2 (
    .clk(clk), .reset(reset), .br_valid(br_valid2),
    .opcode(opcode), .op(op), .cond(cond), .pc(pc),
    .sximm(sximm), .rd_val(rd_val),
    .rspecial_val(rspecial_val),
    .z(z), .n(n), .v(v),
    .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .flush(flush2),
    .stall_ex(stall_ex2), .branch_taken(branch_taken2),
    .busy(busy2), .taken_count(taken_count2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rv,
                         input logic [2:0] fl, input logic st,
                         input logic bs);
    chk({tag, ".rv"}, 32'(redirect_valid), 32'(rv));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".stall"}, 32'(stall_ex), 32'(st));
    chk({tag, ".busy"}, 32'(busy), 32'(bs));
  endtask

  task automatic chk_out2(input string tag, input logic rv,
                          input logic [4:0] fl, input logic st,
                          input logic bs);
    chk({tag, ".rv"}, 32'(redirect_valid2), 32'(rv));
    chk({tag, ".flush"}, 32'(flush2), 32'(fl));
    chk({tag, ".stall"}, 32'(stall_ex2), 32'(st));
    chk({tag, ".busy"}, 32'(busy2), 32'(bs));
  endtask

  task automatic set_k(input logic [7:0] kk);
    {opcode, op, cond} = kk;
  endtask

  // Issue a taken branch, check the target, then drain with ready high.
  task automatic run_taken(input string tag,
                           input logic [8:0] exp_pc);
    redirect_ready = 1'b1;
    br_valid = 1'b1;
    #1;
    chk({tag, ".taken"}, 32'(branch_taken), 32'd1);
    tick();
    br_valid = 1'b0;
    chk({tag, ".pc"}, 32'(redirect_pc), 32'(exp_pc));
    chk_out({tag, ".redir"}, 1'b1, 3'b111, 1'b1, 1'b1);
    repeat (4) tick();
    chk_out({tag, ".idle"}, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic run_not_taken(input string tag);
    br_valid = 1'b1;
    #1;
    chk({tag, ".taken"}, 32'(branch_taken), 32'd0);
    tick();
    br_valid = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".rv"}, 32'(redirect_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    br_valid = 1'b0;
    br_valid2 = 1'b0;
    set_k(8'h00);
    pc = '0;
    sximm = '0;
    rd_val = '0;
    rspecial_val = '0;
    {z, n, v} = 3'b000;
    redirect_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_out("reset", 1'b0, 3'b000, 1'b0, 1'b0);
    chk("reset.cnt", 32'(taken_count), 32'd0);
    chk("reset.pc", 32'(redirect_pc), 32'd0);

    // Unconditional B with full flush sequence
    set_k(8'b00100_000);
    pc = 9'h010;
    sximm = 16'h0005;
    br_valid = 1'b1;
    #1;
    chk("b.taken", 32'(branch_taken), 32'd1);
    tick();
    br_valid = 1'b0;
    chk("b.pc", 32'(redirect_pc), 32'h016);
    chk_out("b.redir", 1'b1, 3'b111, 1'b1, 1'b1);
    tick();
    chk_out("b.f1", 1'b0, 3'b110, 1'b1, 1'b1);
    chk("b.count", 32'(taken_count), 32'd1);
    tick();
    chk_out("b.f2", 1'b0, 3'b100, 1'b1, 1'b1);
    tick();
    chk_out("b.f3", 1'b0, 3'b000, 1'b0, 1'b1);
    tick();
    chk_out("b.idle", 1'b0, 3'b000, 1'b0, 1'b0);

    // Conditional branches
    pc = 9'h020;
    sximm = 16'hFFFE;
    set_k(8'b00100_001);
    {z, n, v} = 3'b000;
    run_not_taken("beq_z0");
    z = 1'b1;
    run_taken("beq_z1", 9'h01F);
    set_k(8'b00100_100);
    {z, n, v} = 3'b010;
    run_taken("ble", 9'h01F);
    set_k(8'b00100_011);
    {z, n, v} = 3'b011;
    run_not_taken("blt_eq");

    // Register targets and wrap
    {z, n, v} = 3'b000;
    set_k(8'b01000_000);
    rd_val = 16'h1ABC;
    run_taken("bx", 9'h0BC);
    set_k(8'b01010_000);
    rspecial_val = 16'h0042;
    run_taken("blx", 9'h042);
    set_k(8'b00100_000);
    pc = 9'h1FF;
    sximm = 16'h0000;
    run_taken("wrap", 9'h000);
    chk("count6", 32'(taken_count), 32'd6);

    // Backpressure, with a second branch offered while waiting
    pc = 9'h010;
    sximm = 16'h0005;
    redirect_ready = 1'b0;
    br_valid = 1'b1;
    tick();
    set_k(8'b01000_000);
    rd_val = 16'h0055;
    z = 1'b1;
    #1;
    chk("bp.ignored", 32'(branch_taken), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("bp.hold", 1'b1, 3'b111, 1'b1, 1'b1);
      chk("bp.pc", 32'(redirect_pc), 32'h016);
    end
    br_valid = 1'b0;
    redirect_ready = 1'b1;
    tick();
    chk_out("bp.f1", 1'b0, 3'b110, 1'b1, 1'b1);
    chk("bp.count", 32'(taken_count), 32'd7);
    tick();
    chk_out("bp.f2", 1'b0, 3'b100, 1'b1, 1'b1);

    // Reset in FLUSH cnt2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("rst.mid", 1'b0, 3'b000, 1'b0, 1'b0);
    chk("rst.count", 32'(taken_count), 32'd0);
    chk("rst.pc", 32'(redirect_pc), 32'd0);
    set_k(8'b00100_000);
    run_taken("after_rst", 9'h016);
    chk("after_rst.count", 32'(taken_count), 32'd1);

    // Deep flush instance
    redirect_ready = 1'b1;
    br_valid2 = 1'b1;
    tick();
    br_valid2 = 1'b0;
    chk("d5.pc", 32'(redirect_pc2), 32'h016);
    chk_out2("d5.redir", 1'b1, 5'b11111, 1'b1, 1'b1);
    tick();
    chk_out2("d5.f1", 1'b0, 5'b11110, 1'b0, 1'b1);
    tick();
    chk_out2("d5.f2", 1'b0, 5'b11100, 1'b0, 1'b1);
    tick();
    chk_out2("d5.f3", 1'b0, 5'b11000, 1'b0, 1'b1);
    tick();
    chk_out2("d5.f4", 1'b0, 5'b10000, 1'b0, 1'b1);
    tick();
    chk_out2("d5.f5", 1'b0, 5'b00000, 1'b0, 1'b1);
    tick();
    chk_out2("d5.idle", 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("d5.count", 32'(taken_count2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
